icache_ctrl: RTL and testbench

ICACHE_CTRL -- requirements
Module: icache_ctrl

---
 rtl/icache_ctrl.sv | 155 +++++++++++++++
 tb/tb_icache_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped instruction cache, 8 lines x 4 words.
// Lookup is combinational against the fetch PC. A miss runs a
// word-by-word refill from word 0 through the mem_req/mem_ack handshake.
module icache_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcF,
  input  logic        inv,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] instrF,
  output logic        stallcF,
  output logic        mem_req,
  output logic [31:0] mem_addr
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int LINES = 8;

  // Fetch address fields
  logic [24:0] pc_tag;
  logic [2:0]  pc_idx;
  logic [1:0]  pc_off;
  logic        unused_pc_lsb;

  assign pc_tag        = pcF[31:7];
  assign pc_idx        = pcF[6:4];
  assign pc_off        = pcF[3:2];
  assign unused_pc_lsb = ^pcF[1:0];

  // Controller state
  logic [1:0]       state_reg, state_next;
  logic [1:0]       cnt_reg, cnt_next;
  logic [24:0]      miss_tag_reg, miss_tag_next;
  logic [2:0]       miss_idx_reg, miss_idx_next;
  logic [LINES-1:0] valid_reg, valid_next;

  // Storage arrays; contents are only meaningful under a set valid bit,
  // so they carry no reset.
  logic [24:0] tag_array  [0:LINES-1];
  logic [31:0] data_array [0:4*LINES-1];

  // Lookup and control strobes
  logic hit;
  logic start_fill;
  logic inv_all;
  logic word_we;
  logic last_word;

  assign hit = (state_reg == S_IDLE) & valid_reg[pc_idx] &
               (tag_array[pc_idx] == pc_tag);

  // Invalidate outranks a fill start on the same edge.
  assign inv_all    = (state_reg == S_IDLE) & inv;
  assign start_fill = (state_reg == S_IDLE) & ~hit & ~inv;
  assign word_we    = (state_reg == S_FILL) & mem_ack;
  assign last_word  = word_we & (cnt_reg == 2'd3);

  // Next-state logic for the FSM, word counter and miss latches
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    miss_tag_next = miss_tag_reg;
    miss_idx_next = miss_idx_reg;
    case (state_reg)
      S_IDLE: begin
        if (start_fill) begin
          state_next    = S_FILL;
          cnt_next      = 2'd0;
          miss_tag_next = pc_tag;
          miss_idx_next = pc_idx;
        end
      end
      S_FILL: begin
        if (word_we) begin
          cnt_next = cnt_reg + 2'd1;
          if (cnt_reg == 2'd3) begin
            state_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Per-line valid update: cleared by invalidate or when its line begins
  // refilling, set when the refill of that line completes.
  generate
    for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
      always_comb begin
        valid_next[gi] = valid_reg[gi];
        if (inv_all) begin
          valid_next[gi] = 1'b0;
        end else if (start_fill && (pc_idx == 3'(gi))) begin
          valid_next[gi] = 1'b0;
        end else if (last_word && (miss_idx_reg == 3'(gi))) begin
          valid_next[gi] = 1'b1;
        end
      end
    end
  endgenerate

  // Control registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      cnt_reg      <= 2'd0;
      miss_tag_reg <= 25'd0;
      miss_idx_reg <= 3'd0;
      valid_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      miss_tag_reg <= miss_tag_next;
      miss_idx_reg <= miss_idx_next;
      valid_reg    <= valid_next;
    end
  end

  // Refill writes into the data array, one word per accepted ack
  always_ff @(posedge clk) begin
    if (word_we) begin
      data_array[{miss_idx_reg, cnt_reg}] <= mem_rdata;
    end
  end

  // Tag is committed together with the valid bit on the final word
  always_ff @(posedge clk) begin
    if (last_word) begin
      tag_array[miss_idx_reg] <= miss_tag_reg;
    end
  end

  // Fetch-side outputs; FILL and DONE never hit, so they always stall
  always_comb begin
    instrF  = hit ? data_array[{pc_idx, pc_off}] : 32'h0;
    stallcF = ~hit;
  end

  // Memory-side outputs, quiet outside FILL
  always_comb begin
    mem_req  = (state_reg == S_FILL);
    mem_addr = (state_reg == S_FILL) ? {miss_tag_reg, miss_idx_reg, cnt_reg, 2'b00}
                                     : 32'h0;
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Testbench for icache_ctrl: directed scenarios plus a randomized fetch
// sequence, checked against a line-level cache model and a fixed memory image.
module tb_icache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pcF = 32'h0;
  logic        inv = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack = 1'b0;
  logic [31:0] instrF;
  logic        stallcF;
  logic        mem_req;
  logic [31:0] mem_addr;

  int checks   = 0;
  int failures = 0;

  // Reference model: which lines hold which tag
  bit          m_valid [8];
  logic [24:0] m_tag   [8];

  icache_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .pcF      (pcF),
    .inv      (inv),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .instrF   (instrF),
    .stallcF  (stallcF),
    .mem_req  (mem_req),
    .mem_addr (mem_addr)
  );

  always #5 clk = ~clk;

  // Backing memory image: a fixed function of the word address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E3779B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
  endtask

  // One fetch: present pc, serve the refill (if any) with 'waits' idle
  // cycles before each ack, and check addresses, latency and data.
  task automatic fetch(input logic [31:0] pc, input int waits, input bit inv_in_fill);
    logic [31:0] base;
    logic [31:0] exp_addr;
    int          idx;
    bit          exp_hit;
    bit          done;
    int          stalls, fills, words, wcnt, exp_stalls, exp_fills;
    base    = {pc[31:4], 4'b0000};
    idx     = int'(pc[6:4]);
    exp_hit = m_valid[idx] && (m_tag[idx] == pc[31:7]);
    done    = 1'b0;
    stalls  = 0; fills = 0; words = 0; wcnt = 0;
    pcF     = pc;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      if (!stallcF) begin
        done = 1'b1;
        checks++;
        if (instrF !== mem_word(pc)) begin
          failures++;
          $display("FAIL fetch_data pc=%h instrF=%h expected=%h", pc, instrF, mem_word(pc));
        end
        checks++;
        if (mem_req !== 1'b0) begin
          failures++;
          $display("FAIL hit_mem_req pc=%h mem_req=%b expected=0", pc, mem_req);
        end
      end else begin
        stalls++;
        if (mem_req === 1'b1) begin
          fills++;
          exp_addr = base + 32'(words * 4);
          checks++;
          if (mem_addr !== exp_addr) begin
            failures++;
            $display("FAIL fill_addr pc=%h mem_addr=%h expected=%h", pc, mem_addr, exp_addr);
          end
          inv = inv_in_fill;
          if (wcnt < waits) begin
            mem_ack = 1'b0;
            mem_rdata = $urandom;
            wcnt++;
          end else begin
            mem_ack = 1'b1;
            mem_rdata = mem_word(exp_addr);
            wcnt = 0;
            words++;
          end
        end else begin
          checks++;
          if (mem_addr !== 32'h0) begin
            failures++;
            $display("FAIL idle_addr pc=%h mem_addr=%h expected=00000000", pc, mem_addr);
          end
          // Acks outside FILL carry garbage and must be ignored
          inv = 1'b0;
          mem_ack = 1'($urandom_range(0, 1));
          mem_rdata = $urandom;
        end
        @(posedge clk);
        #1;
      end
    end
    mem_ack = 1'b0;
    inv = 1'b0;
    if (!done) begin
      failures++;
      $display("FAIL fetch_timeout pc=%h stalls=%0d expected_completion=1", pc, stalls);
    end
    exp_stalls = exp_hit ? 0 : 2 + 4 * (waits + 1);
    exp_fills  = exp_hit ? 0 : 4 * (waits + 1);
    checks++;
    if (stalls != exp_stalls) begin
      failures++;
      $display("FAIL stall_cycles pc=%h stalls=%0d expected=%0d", pc, stalls, exp_stalls);
    end
    checks++;
    if (fills != exp_fills) begin
      failures++;
      $display("FAIL fill_cycles pc=%h fills=%0d expected=%0d", pc, fills, exp_fills);
    end
    $display("fetch pc=%h waits=%0d inv_in_fill=%0d hit=%0d stalls=%0d instr=%h",
             pc, waits, inv_in_fill, exp_hit, stalls, instrF);
    m_valid[idx] = 1'b1;
    m_tag[idx]   = pc[31:7];
    @(posedge clk);
    #1;
  endtask

  // Pulse inv for one IDLE cycle at pc, then fetch pc (which must now miss)
  task automatic pulse_inv(input logic [31:0] pc, input int waits);
    int idx;
    bit exp_hit;
    idx     = int'(pc[6:4]);
    exp_hit = m_valid[idx] && (m_tag[idx] == pc[31:7]);
    pcF = pc;
    inv = 1'b1;
    @(negedge clk);
    checks++;
    if (stallcF !== !exp_hit) begin
      failures++;
      $display("FAIL inv_cycle_stall pc=%h stallcF=%b expected=%b", pc, stallcF, !exp_hit);
    end
    @(posedge clk);
    #1;
    inv = 1'b0;
    model_clear();
    $display("inv pc=%h hit_before=%0d", pc, exp_hit);
    fetch(pc, waits, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < 4; i++) begin
      pcF = $urandom;
      mem_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (instrF !== 32'h0 || stallcF !== 1'b1) begin
        failures++;
        $display("FAIL reset_fetch instrF=%h stallcF=%b expected=00000000/1", instrF, stallcF);
      end
      checks++;
      if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin
        failures++;
        $display("FAIL reset_mem mem_req=%b mem_addr=%h expected=0/00000000", mem_req, mem_addr);
      end
      $display("reset cycle=%0d pc=%h stallcF=%b", i, pcF, stallcF);
    end
    mem_ack = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_cold_miss();
    fetch(32'h0000_0040, 0, 1'b0);
    fetch(32'h0000_004C, 0, 1'b0);
  endtask

  task automatic test_conflict();
    fetch(32'h0000_00C0, 0, 1'b0);
    fetch(32'h0000_00C8, 0, 1'b0);
    fetch(32'h0000_0044, 0, 1'b0);
  endtask

  task automatic test_wait_states();
    fetch(32'h1234_5678, 3, 1'b0);
    fetch(32'h1234_5670, 0, 1'b0);
    fetch(32'h1234_5674, 0, 1'b0);
  endtask

  task automatic test_reset_mid_fill();
    logic [31:0] pc;
    logic [31:0] base;
    int acks;
    pc   = 32'hF000_0280;
    base = {pc[31:4], 4'b0000};
    acks = 0;
    pcF = pc;
    for (int i = 0; i < 20 && acks < 2; i++) begin
      @(negedge clk);
      mem_ack = 1'b1;
      mem_rdata = 32'hDEAD_0000 + 32'(i);
      if (mem_req === 1'b1) acks++;
      @(posedge clk);
    end
    #1;
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== base + 32'h8) begin
      failures++;
      $display("FAIL midfill_addr mem_req=%b mem_addr=%h expected=1/%h", mem_req, mem_addr, base + 32'h8);
    end
    #1;
    rst = 1'b0;
    mem_ack = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0 || stallcF !== 1'b1 || instrF !== 32'h0) begin
      failures++;
      $display("FAIL async_reset mem_req=%b mem_addr=%h stallcF=%b instrF=%h expected=0/00000000/1/00000000",
               mem_req, mem_addr, stallcF, instrF);
    end
    $display("reset_mid_fill pc=%h acks=%0d", pc, acks);
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    fetch(pc, 0, 1'b0);
  endtask

  task automatic test_invalidate();
    fetch(32'h0000_0040, 0, 1'b0);
    pulse_inv(32'h0000_0040, 0);
    fetch(32'h0000_0100, 0, 1'b1);
    fetch(32'h0000_0048, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] pc;
    logic [24:0] tags [4];
    tags[0] = 25'h0;
    tags[1] = 25'h1;
    tags[2] = 25'h0ABCDE;
    tags[3] = 25'h1FFFFFF;
    for (int i = 0; i < 60; i++) begin
      pc = {tags[$urandom_range(0, 3)], 3'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 11) == 0)
        pulse_inv(pc, $urandom_range(0, 2));
      else
        fetch(pc, $urandom_range(0, 2), $urandom_range(0, 3) == 0);
    end
  endtask

  // Back-to-back hits: walk every word of a freshly filled line each cycle
  task automatic test_back_to_back();
    fetch(32'h0000_0370, 1, 1'b0);
    for (int w = 0; w < 4; w++) fetch(32'h0000_0370 + 32'(w * 4), 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_conflict();
    test_wait_states();
    test_reset_mid_fill();
    test_invalidate();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
